gb_link_port: RTL and testbench

Parametrised Game Boy serial link controller: the SB/SC register pair plus the shift engine that moves a DATA_W-bit word out on `serial_data_out` while shifting `serial_data_in` in, MSB first. It runs as clock master (internal divider, normal or CGB fast rate) or clock slave (synchronised external clock), and raises a one-cycle interrupt pulse at end of transfer. It sits between the CPU I/O decode (FF01/FF02 selects) and the link cable pins, and runs on the same `ce` enable as the rest of the GB core.

---
 rtl/link_pkg.sv | 25 ++
 rtl/link_edge_sync.sv | 62 ++++++
 rtl/gb_link_port.sv | 203 ++++++++++++++++++++
 tb/tb_gb_link_port.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the Game Boy serial link port.
// Holds the transfer state enum, default sizing constants and the helper
// that sizes the bit-period divider. Fast-rate support in gb_link_port is
// compiled in only when LINK_FAST_CLK_EN is defined.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_XFER = 2'd1,
    EXT_XFER = 2'd2,
    DONE     = 2'd3
  } link_state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLK_DIV      = 511;  // 8192 Hz bit rate at the normal core rate
  localparam int DEF_CLK_DIV_FAST = 15;   // 262144 Hz CGB fast rate

  // Width that holds the larger of the two divider reload values.
  function automatic int div_width(input int div_a, input int div_b);
    int m;
    m = (div_a > div_b) ? div_a : div_b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/link_edge_sync.sv
// Cable-side input conditioning for the link port.
// Synchronises the asynchronous serial clock and data pins into clk_sys
// and detects rising/falling edges of the synchronised clock.
//
// Ports:
//   clk_sys, rst   system clock, synchronous active-high reset
//   ce             core clock enable; qualifies edge detection only
//   clear          suppresses edge reporting in the cycle a transfer starts
//   clk_in/data_in asynchronous cable inputs
//   data_sync      synchronised data pin
//   rise/fall      one-ce-cycle edge strobes of the synchronised clock pin
module link_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic ce,
  input  logic clear,
  input  logic clk_in,
  input  logic data_in,
  output logic data_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_chain;
  logic [SYNC_STAGES-1:0] data_chain;
  logic                   clk_sync;
  logic                   clk_prev;

  // The flop chain runs every clk_sys so pin latency does not depend on ce.
  // NOTE: the chain is reset to the idle-high cable level so leaving reset
  // never looks like a clock edge.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      clk_chain  <= '1;
      data_chain <= '1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      clk_chain  <= {clk_chain[SYNC_STAGES-2:0], clk_in};
      data_chain <= {data_chain[SYNC_STAGES-2:0], data_in};
    end
  end

  assign clk_sync  = clk_chain[SYNC_STAGES-1];
  assign data_sync = data_chain[SYNC_STAGES-1];

  // History advances with the core so a pin edge seen while ce=0 is still
  // reported on the next enabled cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      clk_prev <= 1'b1;
    end else if (ce) begin
      clk_prev <= clk_sync;
    end
  end

  assign rise = ce & ~clear &  clk_sync & ~clk_prev;
  assign fall = ce & ~clear & ~clk_sync &  clk_prev;

endmodule

// File: rtl/gb_link_port.sv
// Game Boy serial link controller: SB/SC registers plus the shift engine.
// Shifts sb out MSB first on serial_data_out while shifting serial_data_in
// in, as clock master (internal divider) or clock slave (cable clock), and
// pulses serial_irq for one ce cycle at the end of a transfer.
// Build option: define LINK_FAST_CLK_EN to enable the SC fast-rate bit.
//
// Ports:
//   clk_sys, rst, ce            clock, synchronous active-high reset, core enable
//   sel_sb, sel_sc, cpu_wr_n    CPU register selects and active-low write strobe
//   sb_in                       SB write data
//   sc_start_in/int_clock_in/fast_in  SC write bits 7, 0, 1
//   serial_clk_in/data_in       asynchronous cable inputs
//   serial_clk_out/data_out     cable outputs (idle high)
//   sb, sc_start, sc_int_clock, sc_fast  register contents
//   busy, serial_irq            transfer active, transfer-complete pulse
module gb_link_port
  import link_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CLK_DIV_FAST = DEF_CLK_DIV_FAST,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              ce,
  input  logic              sel_sb,
  input  logic              sel_sc,
  input  logic              cpu_wr_n,
  input  logic [DATA_W-1:0] sb_in,
  input  logic              sc_start_in,
  input  logic              sc_int_clock_in,
  input  logic              sc_fast_in,
  input  logic              serial_clk_in,
  input  logic              serial_data_in,
  output logic              serial_clk_out,
  output logic              serial_data_out,
  output logic [DATA_W-1:0] sb,
  output logic              sc_start,
  output logic              sc_int_clock,
  output logic              sc_fast,
  output logic              busy,
  output logic              serial_irq
);

  localparam int DIV_W = div_width(CLK_DIV, CLK_DIV_FAST);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_NORM  = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_NORM = DIV_W'(CLK_DIV / 2 + 1);

  link_state_e      state;
  link_state_e      state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_start;   // reload used by the SC write that starts a transfer
  logic [DIV_W-1:0] div_reload;  // reload used between bits of a running transfer
  logic [DIV_W-1:0] div_half;    // divider value at which the clock pin falls
  logic [DATA_W-1:0] sb_cur;
  logic             sc_wr;
  logic             sb_wr;
  logic             data_sync;
  logic             ext_rise;
  logic             ext_fall;

  // SC wins over SB when both are selected in the same write.
  assign sc_wr = ce & ~cpu_wr_n & sel_sc;
  assign sb_wr = ce & ~cpu_wr_n & sel_sb & ~sel_sc;

  // A CPU write to SB mid-transfer is shifted immediately, not one bit later.
  assign sb_cur = sb_wr ? sb_in : sb;

`ifdef LINK_FAST_CLK_EN
  localparam logic [DIV_W-1:0] DIV_FAST  = DIV_W'(CLK_DIV_FAST);
  localparam logic [DIV_W-1:0] HALF_FAST = DIV_W'(CLK_DIV_FAST / 2 + 1);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sc_fast <= 1'b0;
    end else if (sc_wr) begin
      sc_fast <= sc_fast_in;
    end
  end

  assign div_start  = sc_fast_in ? DIV_FAST  : DIV_NORM;
  assign div_reload = sc_fast    ? DIV_FAST  : DIV_NORM;
  assign div_half   = sc_fast    ? HALF_FAST : HALF_NORM;
`else
  logic unused_sc_fast_in;
  assign unused_sc_fast_in = sc_fast_in;
  assign sc_fast    = 1'b0;
  assign div_start  = DIV_NORM;
  assign div_reload = DIV_NORM;
  assign div_half   = HALF_NORM;
`endif

  link_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .ce       (ce),
    .clear    (sc_wr & sc_start_in),
    .clk_in   (serial_clk_in),
    .data_in  (serial_data_in),
    .data_sync(data_sync),
    .rise     (ext_rise),
    .fall     (ext_fall)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: assigning the default first keeps every path covered, so no
    // latch is inferred for state_nxt.
    state_nxt = state;
    if (ce) begin
      if (sc_wr) begin
        // Start (or restart) from the beginning; start=0 aborts silently.
        if (sc_start_in) begin
          state_nxt = sc_int_clock_in ? INT_XFER : EXT_XFER;
        end else begin
          state_nxt = IDLE;
        end
      end else begin
        case (state)
          INT_XFER: if (bit_cnt == '0) state_nxt = DONE;
          EXT_XFER: if (ext_rise && bit_cnt == CNT_W'(1)) state_nxt = DONE;
          DONE:     state_nxt = IDLE;
          default:  state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sb              <= '0;
      sc_start        <= 1'b0;
      sc_int_clock    <= 1'b0;
      serial_clk_out  <= 1'b1;
      serial_data_out <= 1'b1;
      div_cnt         <= '0;
      bit_cnt         <= '0;
    end else if (ce) begin
      if (sc_wr) begin
        sc_start       <= sc_start_in;
        sc_int_clock   <= sc_int_clock_in;
        serial_clk_out <= 1'b1;
        if (sc_start_in) begin
          bit_cnt <= CNT_W'(DATA_W);
          div_cnt <= div_start;
        end
      end else begin
        sb <= sb_cur;
        case (state)
          INT_XFER: begin
            // bit_cnt==0 is the one idle cycle before DONE; nothing moves.
            if (bit_cnt != '0) begin
              if (div_cnt == '0) begin
                serial_clk_out <= 1'b1;
                sb             <= {sb_cur[DATA_W-2:0], data_sync};
                bit_cnt        <= bit_cnt - CNT_W'(1);
                div_cnt        <= div_reload;
              end else begin
                div_cnt <= div_cnt - DIV_W'(1);
                if (div_cnt == div_half) begin
                  serial_clk_out  <= 1'b0;
                  serial_data_out <= sb_cur[DATA_W-1];
                end
              end
            end
          end
          EXT_XFER: begin
            if (ext_fall) begin
              serial_data_out <= sb_cur[DATA_W-1];
            end
            if (ext_rise && bit_cnt != '0) begin
              sb      <= {sb_cur[DATA_W-2:0], data_sync};
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
          DONE:    serial_clk_out <= 1'b1;
          default: ;
        endcase
        // Clear start as DONE is entered so it reads 0 alongside the irq.
        if (state_nxt == DONE && state != DONE) begin
          sc_start <= 1'b0;
        end
      end
    end
  end

  assign busy       = (state == INT_XFER) || (state == EXT_XFER);
  assign serial_irq = (state == DONE);

endmodule

// File: tb/tb_gb_link_port.sv
// Directed bench for gb_link_port: a default-parameter instance (u0) and a
// DATA_W=16 / CLK_DIV=3 instance (u1). Expected transfer results are queued
// when a transfer is started and popped when the DUT raises serial_irq.
module tb_gb_link_port;

  typedef struct {
    string       tag;
    int          t0;
    int          lat;
    logic [15:0] sbv;
  } exp_t;

  exp_t sb_q[$];

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int scyc = 0;   // clk_sys edges
  int ccyc = 0;   // ce edges of u1
  logic ce2;
  always @(posedge clk_sys) scyc <= scyc + 1;
  assign ce2 = scyc[0];
  always @(posedge clk_sys) if (ce2) ccyc <= ccyc + 1;

  logic        rst = 1'b1;
  logic        ce0 = 1'b1;
  logic        sel_sb0 = 1'b0, sel_sc0 = 1'b0, sel_sb1 = 1'b0, sel_sc1 = 1'b0;
  logic        cpu_wr_n = 1'b1;
  logic [15:0] sb_in = '0;
  logic        sc_start_in = 1'b0, sc_int_clock_in = 1'b0, sc_fast_in = 1'b0;
  logic        sclk0 = 1'b1, tb_din = 1'b0, loop0 = 1'b1;
  logic        din0;
  logic        sco0, sdo0, st0, ic0, fs0, busy0, irq0;
  logic [7:0]  sb0;
  logic        sco1, sdo1, st1, ic1, fs1, busy1, irq1;
  logic [15:0] sb1;

  assign din0 = loop0 ? sdo0 : tb_din;

  gb_link_port u0 (
    .clk_sys(clk_sys), .rst(rst), .ce(ce0),
    .sel_sb(sel_sb0), .sel_sc(sel_sc0), .cpu_wr_n(cpu_wr_n),
    .sb_in(sb_in[7:0]), .sc_start_in(sc_start_in),
    .sc_int_clock_in(sc_int_clock_in), .sc_fast_in(sc_fast_in),
    .serial_clk_in(sclk0), .serial_data_in(din0),
    .serial_clk_out(sco0), .serial_data_out(sdo0), .sb(sb0),
    .sc_start(st0), .sc_int_clock(ic0), .sc_fast(fs0),
    .busy(busy0), .serial_irq(irq0)
  );

  gb_link_port #(.DATA_W(16), .CLK_DIV(3)) u1 (
    .clk_sys(clk_sys), .rst(rst), .ce(ce2),
    .sel_sb(sel_sb1), .sel_sc(sel_sc1), .cpu_wr_n(cpu_wr_n),
    .sb_in(sb_in), .sc_start_in(sc_start_in),
    .sc_int_clock_in(sc_int_clock_in), .sc_fast_in(sc_fast_in),
    .serial_clk_in(1'b1), .serial_data_in(sdo1),
    .serial_clk_out(sco1), .serial_data_out(sdo1), .sb(sb1),
    .sc_start(st1), .sc_int_clock(ic1), .sc_fast(fs1),
    .busy(busy1), .serial_irq(irq1)
  );

  int n_vec = 0;
  int n_err = 0;
  int t_last = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU write; t_last receives the ce-cycle index of the capturing edge.
  task automatic bus_write(input bit which, input bit wsb, input bit wsc,
                           input logic [15:0] d, input bit st, input bit ic, input bit fs);
    @(negedge clk_sys);
    if (which) while (!ce2) @(negedge clk_sys);
    sb_in = d; sc_start_in = st; sc_int_clock_in = ic; sc_fast_in = fs;
    if (which) begin sel_sb1 = wsb; sel_sc1 = wsc; end
    else       begin sel_sb0 = wsb; sel_sc0 = wsc; end
    cpu_wr_n = 1'b0;
    t_last = which ? ccyc + 1 : scyc + 1;
    @(negedge clk_sys);
    sel_sb0 = 1'b0; sel_sc0 = 1'b0; sel_sb1 = 1'b0; sel_sc1 = 1'b0;
    cpu_wr_n = 1'b1;
  endtask

  task automatic expect_irq(input string tag, input int t0, input int lat, input logic [15:0] sbv);
    exp_t e;
    e.tag = tag; e.t0 = t0; e.lat = lat; e.sbv = sbv;
    sb_q.push_back(e);
  endtask

  task automatic wait_irq(input bit which, input int budget);
    exp_t e;
    bit seen;
    int lat;
    logic [15:0] sbv;
    e = sb_q.pop_front();
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_sys);
      if ((which ? irq1 : irq0) === 1'b1) begin
        seen = 1'b1;
        lat = (which ? ccyc : scyc) - e.t0;
      end
    end
    check({e.tag, "/irq_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({e.tag, "/irq_latency"}, lat, e.lat);
      sbv = which ? sb1 : {8'h00, sb0};
      check({e.tag, "/sb"}, 32'(sbv), 32'(e.sbv));
      repeat (which ? 2 : 1) @(negedge clk_sys);
      check({e.tag, "/irq_single"}, 32'(which ? irq1 : irq0), 32'd0);
    end
  endtask

  task automatic count_irq0(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (irq0 === 1'b1) hits++;
    end
  endtask

  initial begin
    int t;
    int hits;
    int lat;
    logic [7:0] pat;
    logic [7:0] sent;

    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);

    // Reset state
    check("rst/sb", 32'(sb0), 32'h0);
    check("rst/sc", 32'({st0, ic0, fs0}), 32'h0);
    check("rst/busy_irq", 32'({busy0, irq0}), 32'h0);
    check("rst/pins", 32'({sco0, sdo0}), 32'h3);

    // Internal clock, normal rate, looped back
    loop0 = 1'b1;
    bus_write(0, 1, 0, 16'h00A5, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    t = t_last;
    expect_irq("int_default", t, 4097, 16'h00A5);
    check("int_default/busy", 32'({busy0, st0}), 32'h3);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(negedge clk_sys);
      if (sco0 === 1'b0) lat = scyc - t;
    end
    check("int_default/first_fall", lat, 256);
    wait_irq(0, 5000);
    check("int_default/sc_start_cleared", 32'({st0, busy0}), 32'h0);

    // Fast rate request
    loop0 = 1'b0;
    tb_din = 1'b1;
    bus_write(0, 1, 0, 16'h003C, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 1);
`ifdef LINK_FAST_CLK_EN
    expect_irq("fast", t_last, 129, 16'h00FF);
    check("fast/sc_fast", 32'(fs0), 32'd1);
`else
    expect_irq("fast", t_last, 4097, 16'h00FF);
    check("fast/sc_fast", 32'(fs0), 32'd0);
`endif
    wait_irq(0, 5000);

    // External clock
    tb_din = 1'b0;
    bus_write(0, 1, 0, 16'h0081, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 0, 0);
    check("ext/started", 32'({busy0, st0, ic0}), 32'h6);
    pat = 8'h5A;
    sent = 8'h81;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      sclk0 = 1'b0;
      tb_din = pat[7-k];
      repeat (6) @(negedge clk_sys);
      check($sformatf("ext/data_out_bit%0d", k), 32'(sdo0), 32'(sent[7-k]));
      repeat (4) @(negedge clk_sys);
      if (k == 7) expect_irq("ext", scyc, 3, 16'h005A);
      sclk0 = 1'b1;
      if (k < 7) repeat (10) @(negedge clk_sys);
    end
    wait_irq(0, 50);
    // A ninth pulse after completion is ignored
    sclk0 = 1'b0;
    tb_din = 1'b1;
    count_irq0(10, hits);
    sclk0 = 1'b1;
    count_irq0(10, lat);
    check("ext/ninth_no_irq", hits + lat, 0);
    check("ext/ninth_state", 32'({sb0, busy0, sdo0}), 32'({8'h5A, 1'b0, 1'b1}));

    // Abort mid-transfer
    loop0 = 1'b1;
    bus_write(0, 1, 0, 16'h00A5, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    t = t_last;
    while (scyc < t + 998) @(negedge clk_sys);
    check("abort/clk_low_before", 32'(sco0), 32'd0);
    bus_write(0, 0, 1, 16'h0000, 0, 1, 0);
    check("abort/idle", 32'({busy0, sco0, st0}), 32'h2);
    count_irq0(4300, hits);
    check("abort/no_irq", hits, 0);

    // Restart mid-transfer: one bit already rotated in (A5 -> 4B)
    bus_write(0, 1, 0, 16'h00A5, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    t = t_last;
    while (scyc < t + 998) @(negedge clk_sys);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    expect_irq("restart", t_last, 4097, 16'h004B);
    wait_irq(0, 5000);

    // SC and SB selected together: SC wins
    bus_write(0, 1, 1, 16'h00EE, 0, 0, 0);
    check("simul/sb_kept", 32'(sb0), 32'h4B);
    check("simul/sc_written", 32'({st0, ic0}), 32'h0);

    // ce held low for 100 cycles mid-transfer
    bus_write(0, 1, 0, 16'h00A5, 0, 0, 0);
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    t = t_last;
    expect_irq("ce_gap", t, 4197, 16'h00A5);
    while (scyc < t + 1998) @(negedge clk_sys);
    ce0 = 1'b0;
    repeat (100) @(negedge clk_sys);
    ce0 = 1'b1;
    wait_irq(0, 3000);

    // Reset mid-transfer
    bus_write(0, 0, 1, 16'h0000, 1, 1, 0);
    t = t_last;
    while (scyc < t + 500) @(negedge clk_sys);
    check("rst_mid/clk_low_before", 32'(sco0), 32'd0);
    rst = 1'b1;
    @(negedge clk_sys);
    check("rst_mid/outputs", 32'({sb0, st0, busy0, sco0, sdo0}), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b1}));
    rst = 1'b0;
    count_irq0(4300, hits);
    check("rst_mid/no_irq", hits, 0);

    // 16-bit word, CLK_DIV=3, ce at half rate
    bus_write(1, 1, 0, 16'hBEEF, 0, 0, 0);
    bus_write(1, 0, 1, 16'h0000, 1, 1, 0);
    expect_irq("w16", t_last, 65, 16'hBEEF);
    wait_irq(1, 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
